// File: rtl/act_drain_if.sv
// Handshake bundle between the activation stage, the row drain and the 32-bit reader.
// The slave modport is the drain's view; the master modport drives rows in and beats out.
interface act_drain_if #(
  parameter int DEPTH = 4
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic          act_valid;
  logic [63:0]   act_data;
  logic          act_ready;
  logic          rd_valid;
  logic          rd_ready;
  logic [31:0]   rd_data;
  logic          rd_last;
  logic [CW-1:0] count;
  logic          overflow;
  logic          clr_ovf;

  modport slave (
    input  act_valid, act_data, rd_ready, clr_ovf,
    output act_ready, rd_valid, rd_data, rd_last, count, overflow
  );

  modport master (
    output act_valid, act_data, rd_ready, clr_ovf,
    input  act_ready, rd_valid, rd_data, rd_last, count, overflow
  );
endinterface

// File: rtl/act_drain.sv
// Buffers 64-bit activation rows in a small FIFO and drains each one as two
// 32-bit beats (low word first) toward a possibly back-pressured reader.
module act_drain #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  act_drain_if.slave  bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic {
    BEAT_LO = 1'b0,
    BEAT_HI = 1'b1
  } beat_e;

  logic [63:0]   mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  beat_e         beat_q, beat_d;
  logic          ovf_q, ovf_d;

  logic          full;
  logic          empty;
  logic          push;
  logic          ovf_set;
  logic          rd_hs;
  logic          pop;
  logic [63:0]   head;
  logic [31:0]   rd_word;

  // Full/empty come only from the occupancy counter; pointers wrap naturally.
  always_comb begin
    full    = (count_q == FULL_CNT);
    empty   = (count_q == '0);
    push    = bus.act_valid && !full;
    ovf_set = bus.act_valid && full;
    rd_hs   = !empty && bus.rd_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q <= BEAT_LO;
    end else begin
      beat_q <= beat_d;
    end
  end

  always_comb begin
    beat_d = beat_q;
    pop    = 1'b0;
    case (beat_q)
      BEAT_LO: begin
        if (rd_hs) beat_d = BEAT_HI;
      end
      BEAT_HI: begin
        if (rd_hs) begin
          beat_d = BEAT_LO;
          pop    = 1'b1;
        end
      end
      default: beat_d = BEAT_LO;
    endcase
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q + CW'(push) - CW'(pop);
    ovf_d   = ovf_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    // A fresh overflow outranks a clear arriving in the same cycle.
    if (ovf_set)          ovf_d = 1'b1;
    else if (bus.clr_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Row storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= bus.act_data;
  end

  assign head = mem_q[rptr_q];

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign rd_word[8*gi +: 8] = (beat_q == BEAT_HI) ? head[8*(gi+4) +: 8]
                                                    : head[8*gi +: 8];
  end

  assign bus.act_ready = !full;
  assign bus.rd_valid  = !empty;
  assign bus.rd_data   = rd_word;
  assign bus.rd_last   = !empty && (beat_q == BEAT_HI);
  assign bus.count     = count_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_act_drain.sv
// Directed bench for act_drain: inputs change 1 time unit after a rising edge,
// outputs are checked in the same window, well away from the next edge.
module tb_act_drain;
  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  act_drain_if #(.DEPTH(4)) bus ();

  act_drain #(.DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] fill_row(input int k);
    fill_row = {32'h1111_0000 + 32'(k), 32'h2222_0000 + 32'(k)};
  endfunction

  task automatic test_reset();
    vectors++;
    if (bus.rd_valid !== 1'b0 || bus.count !== 3'd0 || bus.act_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_state: rd_valid=%b count=%0d act_ready=%b, want 0/0/1",
               bus.rd_valid, bus.count, bus.act_ready);
    end
    vectors++;
    if (bus.overflow !== 1'b0 || bus.rd_last !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags: overflow=%b rd_last=%b, want 0/0", bus.overflow, bus.rd_last);
    end
    bus.act_data  = 64'h0102_0304_0506_0708;
    bus.act_valid = 1'b1;
    tick();
    bus.act_valid = 1'b0;
    vectors++;
    if (bus.count !== 3'd1 || bus.rd_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_prepush: count=%0d rd_valid=%b, want 1/1", bus.count, bus.rd_valid);
    end
    #3;
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.rd_valid !== 1'b0 || bus.count !== 3'd0 || bus.act_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_async: rd_valid=%b count=%0d act_ready=%b, want 0/0/1",
               bus.rd_valid, bus.count, bus.act_ready);
    end
    tick();
    rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_basic();
    bus.act_data  = 64'h8877_6655_4433_2211;
    bus.act_valid = 1'b1;
    bus.rd_ready  = 1'b1;
    tick();
    bus.act_valid = 1'b0;
    vectors++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 32'h4433_2211 || bus.rd_last !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_lo: valid=%b data=%h last=%b, want 1/44332211/0",
               bus.rd_valid, bus.rd_data, bus.rd_last);
    end
    tick();
    vectors++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 32'h8877_6655 || bus.rd_last !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_hi: valid=%b data=%h last=%b, want 1/88776655/1",
               bus.rd_valid, bus.rd_data, bus.rd_last);
    end
    tick();
    vectors++;
    if (bus.rd_valid !== 1'b0 || bus.count !== 3'd0) begin
      miscompares++;
      $display("FAIL basic_empty: valid=%b count=%0d, want 0/0", bus.rd_valid, bus.count);
    end
    bus.rd_ready = 1'b0;
    $display("test_basic done");
  endtask

  task automatic test_fill_overflow();
    bus.rd_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      bus.act_data  = fill_row(k);
      bus.act_valid = 1'b1;
      tick();
      if (k == 4) begin
        vectors++;
        if (bus.count !== 3'd4 || bus.act_ready !== 1'b0 || bus.overflow !== 1'b0) begin
          miscompares++;
          $display("FAIL fill_full: count=%0d act_ready=%b ovf=%b, want 4/0/0",
                   bus.count, bus.act_ready, bus.overflow);
        end
      end
    end
    bus.act_valid = 1'b0;
    vectors++;
    if (bus.count !== 3'd4 || bus.overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL fill_ovf: count=%0d ovf=%b, want 4/1", bus.count, bus.overflow);
    end
    bus.rd_ready = 1'b1;
    for (int b = 0; b < 8; b++) begin
      logic [63:0] r;
      logic [31:0] exp_w;
      r = fill_row(b / 2 + 1);
      exp_w = (b % 2 == 1) ? r[63:32] : r[31:0];
      vectors++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_w || bus.rd_last !== 1'(b % 2)) begin
        miscompares++;
        $display("FAIL fill_drain beat %0d: valid=%b data=%h last=%b, want 1/%h/%0d",
                 b, bus.rd_valid, bus.rd_data, bus.rd_last, exp_w, b % 2);
      end
      tick();
    end
    bus.rd_ready = 1'b0;
    vectors++;
    if (bus.rd_valid !== 1'b0 || bus.overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL fill_after: valid=%b ovf=%b, want 0/1 (sticky)", bus.rd_valid, bus.overflow);
    end
    bus.clr_ovf = 1'b1;
    tick();
    bus.clr_ovf = 1'b0;
    vectors++;
    if (bus.overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL fill_clr: ovf=%b, want 0", bus.overflow);
    end
    $display("test_fill_overflow done");
  endtask

  task automatic test_backpressure();
    logic        rdy_seq  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] data_seq [5] = '{32'hCAFE_F00D, 32'hCAFE_F00D, 32'hDEAD_BEEF,
                                  32'hDEAD_BEEF, 32'hDEAD_BEEF};
    logic        last_seq [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    bus.rd_ready  = 1'b0;
    bus.act_data  = 64'hDEAD_BEEF_CAFE_F00D;
    bus.act_valid = 1'b1;
    tick();
    bus.act_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.rd_ready = rdy_seq[i];
      vectors++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== data_seq[i] ||
          bus.rd_last !== last_seq[i] || bus.count !== 3'd1) begin
        miscompares++;
        $display("FAIL bp cycle %0d: valid=%b data=%h last=%b count=%0d, want 1/%h/%b/1",
                 i, bus.rd_valid, bus.rd_data, bus.rd_last, bus.count, data_seq[i], last_seq[i]);
      end
      tick();
    end
    bus.rd_ready = 1'b0;
    vectors++;
    if (bus.rd_valid !== 1'b0 || bus.count !== 3'd0) begin
      miscompares++;
      $display("FAIL bp_end: valid=%b count=%0d, want 0/0", bus.rd_valid, bus.count);
    end
    $display("test_backpressure done");
  endtask

  task automatic test_concurrent_full();
    bus.rd_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      bus.act_data  = fill_row(k);
      bus.act_valid = 1'b1;
      tick();
    end
    bus.act_valid = 1'b0;
    bus.rd_ready  = 1'b1;
    tick();
    bus.act_data  = 64'hBAD0_BAD0_BAD0_BAD0;
    bus.act_valid = 1'b1;
    vectors++;
    if (bus.count !== 3'd4 || bus.rd_last !== 1'b1 || bus.act_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL conc_pre: count=%0d last=%b act_ready=%b, want 4/1/0",
               bus.count, bus.rd_last, bus.act_ready);
    end
    tick();
    bus.act_valid = 1'b0;
    bus.rd_ready  = 1'b0;
    vectors++;
    if (bus.count !== 3'd3 || bus.overflow !== 1'b1 || bus.act_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL conc_post: count=%0d ovf=%b act_ready=%b, want 3/1/1",
               bus.count, bus.overflow, bus.act_ready);
    end
    bus.rd_ready = 1'b1;
    for (int b = 0; b < 6; b++) begin
      logic [63:0] r;
      logic [31:0] exp_w;
      r = fill_row(b / 2 + 2);
      exp_w = (b % 2 == 1) ? r[63:32] : r[31:0];
      vectors++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_w) begin
        miscompares++;
        $display("FAIL conc_drain beat %0d: valid=%b data=%h, want 1/%h",
                 b, bus.rd_valid, bus.rd_data, exp_w);
      end
      tick();
    end
    bus.rd_ready = 1'b0;
    vectors++;
    if (bus.rd_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL conc_empty: valid=%b, want 0", bus.rd_valid);
    end
    bus.clr_ovf = 1'b1;
    tick();
    bus.clr_ovf = 1'b0;
    $display("test_concurrent_full done");
  endtask

  task automatic test_wrap();
    int b;
    b = 0;
    bus.rd_ready = 1'b1;
    for (int c = 0; c < 24; c++) begin
      logic [7:0]  k8;
      logic [31:0] exp_w;
      k8 = 8'(c / 2);
      bus.act_valid = (c % 2 == 0) && (c / 2 < 10);
      bus.act_data  = {8{k8}};
      vectors++;
      if (bus.count > 3'd2 || bus.overflow !== 1'b0) begin
        miscompares++;
        $display("FAIL wrap_occ cycle %0d: count=%0d ovf=%b, want <=2/0", c, bus.count, bus.overflow);
      end
      if (b > 0 && b < 20) begin
        vectors++;
        if (bus.rd_valid !== 1'b1) begin
          miscompares++;
          $display("FAIL wrap_gap cycle %0d: rd_valid=%b, want 1", c, bus.rd_valid);
        end
      end
      if (bus.rd_valid === 1'b1) begin
        k8 = 8'(b / 2);
        exp_w = {4{k8}};
        vectors++;
        if (bus.rd_data !== exp_w || bus.rd_last !== 1'(b % 2)) begin
          miscompares++;
          $display("FAIL wrap_beat %0d: data=%h last=%b, want %h/%0d",
                   b, bus.rd_data, bus.rd_last, exp_w, b % 2);
        end
        b++;
      end
      tick();
    end
    bus.act_valid = 1'b0;
    bus.rd_ready  = 1'b0;
    vectors++;
    if (b != 20) begin
      miscompares++;
      $display("FAIL wrap_total: beats=%0d, want 20", b);
    end
    $display("test_wrap done, %0d beats", b);
  endtask

  task automatic test_reset_mid_row();
    bus.rd_ready  = 1'b0;
    bus.act_data  = 64'h0123_4567_89AB_CDEF;
    bus.act_valid = 1'b1;
    tick();
    bus.act_valid = 1'b0;
    bus.rd_ready  = 1'b1;
    tick();
    bus.rd_ready = 1'b0;
    vectors++;
    if (bus.rd_last !== 1'b1 || bus.rd_data !== 32'h0123_4567) begin
      miscompares++;
      $display("FAIL midrow_hi: last=%b data=%h, want 1/01234567", bus.rd_last, bus.rd_data);
    end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.rd_valid !== 1'b0 || bus.rd_last !== 1'b0) begin
      miscompares++;
      $display("FAIL midrow_rst: valid=%b last=%b, want 0/0", bus.rd_valid, bus.rd_last);
    end
    tick();
    rst = 1'b0;
    bus.act_data  = 64'hFEDC_BA98_7654_3210;
    bus.act_valid = 1'b1;
    tick();
    bus.act_valid = 1'b0;
    vectors++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 32'h7654_3210 || bus.rd_last !== 1'b0) begin
      miscompares++;
      $display("FAIL midrow_b_lo: valid=%b data=%h last=%b, want 1/76543210/0",
               bus.rd_valid, bus.rd_data, bus.rd_last);
    end
    bus.rd_ready = 1'b1;
    tick();
    vectors++;
    if (bus.rd_data !== 32'hFEDC_BA98 || bus.rd_last !== 1'b1) begin
      miscompares++;
      $display("FAIL midrow_b_hi: data=%h last=%b, want fedcba98/1", bus.rd_data, bus.rd_last);
    end
    tick();
    bus.rd_ready = 1'b0;
    vectors++;
    if (bus.rd_valid !== 1'b0 || bus.count !== 3'd0) begin
      miscompares++;
      $display("FAIL midrow_end: valid=%b count=%0d, want 0/0", bus.rd_valid, bus.count);
    end
    $display("test_reset_mid_row done");
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst           = 1'b1;
    bus.act_valid = 1'b0;
    bus.act_data  = '0;
    bus.rd_ready  = 1'b0;
    bus.clr_ovf   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    test_reset();
    test_basic();
    test_fill_overflow();
    test_backpressure();
    test_concurrent_full();
    test_wrap();
    test_reset_mid_row();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
